// File: rtl/mac_ifmaps_feeder.sv
// MAC ifmaps FIFO producer: walks 5-row bands column by column through a 1-cycle
// row memory and pushes one column slice per FIFO write through a 2-entry staging buffer.

// One row of the staging buffer. Entry 0 is the head; a pop shifts entry 1 forward.
module mac_ifmaps_feeder_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pop,
  input  logic         push,
  input  logic         slot,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;

  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    if (pop) e0_d = e1_q;
    // slot is the post-pop occupancy, so the write lands right behind what remains
    if (push) begin
      if (slot) e1_d = wdata;
      else      e0_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end

  assign head = e0_q;
endmodule

module mac_ifmaps_feeder #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_W     = 10,
  parameter int COL_W      = 8,
  parameter int BAND_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COL_W-1:0]      cfg_cols,
  input  logic [BAND_W-1:0]     cfg_bands,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata_row0,
  input  logic [DATA_WIDTH-1:0] bram_rdata_row1,
  input  logic [DATA_WIDTH-1:0] bram_rdata_row2,
  input  logic [DATA_WIDTH-1:0] bram_rdata_row3,
  input  logic [DATA_WIDTH-1:0] bram_rdata_row4,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row0_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row1_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row2_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row3_in,
  output logic [DATA_WIDTH-1:0] ifmaps_fifo_row4_in,
  output logic                  ifmaps_input_valid,
  input  logic                  fifo_full,
  input  logic                  fifo_read
);
  localparam int NUM_ROWS = 5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    cols_q, cols_d, col_q, col_d;
  logic [BAND_W-1:0]   bands_q, bands_d, band_q, band_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          occ_q, occ_d;
  logic                rd_vld_q, rd_vld_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic                accept, rd_en;
  logic [1:0]          occ_pop;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0] rdata, head;

  assign rdata = {bram_rdata_row4, bram_rdata_row3, bram_rdata_row2,
                  bram_rdata_row1, bram_rdata_row0};

  assign ifmaps_input_valid = (occ_q != 2'd0);
  assign accept  = ifmaps_input_valid & (~fifo_full | fifo_read);
  assign occ_pop = occ_q - {1'b0, accept};
  // Staging plus in-flight never exceeds 2, so an unconditional write cannot overflow
  assign rd_en   = (state_q == S_RUN) &&
                   (({1'b0, occ_pop} + {2'b00, rd_vld_q}) < 3'd2);
  assign occ_d   = occ_pop + {1'b0, rd_vld_q};
  assign rd_vld_d = rd_en;

  assign bram_en   = rd_en;
  assign bram_addr = rd_en ? (base_q + ADDR_W'(col_q)) : '0;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    bands_d = bands_q;
    col_d   = col_q;
    band_d  = band_q;
    base_d  = base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_cols != '0 && cfg_bands != '0) begin
            state_d = S_RUN;
            cols_d  = cfg_cols;
            bands_d = cfg_bands;
            col_d   = '0;
            band_d  = '0;
            base_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (col_q == cols_q - COL_W'(1)) begin
            col_d  = '0;
            base_d = base_q + ADDR_W'(cols_q);
            band_d = band_q + BAND_W'(1);
            if (band_q == bands_q - BAND_W'(1)) state_d = S_DRAIN;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Look at next-cycle occupancy so done lands right after the final accept
        if (occ_d == 2'd0 && !rd_vld_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cols_q   <= '0;
      bands_q  <= '0;
      col_q    <= '0;
      band_q   <= '0;
      base_q   <= '0;
      occ_q    <= '0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      bands_q  <= bands_d;
      col_q    <= col_d;
      band_q   <= band_d;
      base_q   <= base_d;
      occ_q    <= occ_d;
      rd_vld_q <= rd_vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    mac_ifmaps_feeder_lane #(.W(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .pop   (accept),
      .push  (rd_vld_q),
      .slot  (occ_pop[0]),
      .wdata (rdata[r]),
      .head  (head[r])
    );
  end

  assign ifmaps_fifo_row0_in = head[0];
  assign ifmaps_fifo_row1_in = head[1];
  assign ifmaps_fifo_row2_in = head[2];
  assign ifmaps_fifo_row3_in = head[3];
  assign ifmaps_fifo_row4_in = head[4];
endmodule

// File: tb/tb_mac_ifmaps_feeder.sv
// Bench for mac_ifmaps_feeder: queue-based scoreboard of expected addresses and slices,
// plus literal latency/count expectations for directed jobs.
module tb_mac_ifmaps_feeder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_cols = '0;
  logic [5:0] cfg_bands = '0;
  logic       busy, done, bram_en, valid;
  logic [9:0] bram_addr;
  logic       fifo_full = 1'b0, fifo_read = 1'b0;
  logic [4:0] memv = '0;
  logic       o0, o1, o2, o3, o4;
  logic [4:0] rows;

  int checks = 0, failures = 0;
  int rd_q[$];
  logic [4:0] exp_q[$];
  int exp_total = 0, issued = 0, acc_cnt = 0;
  bit start_live = 0, busy_due = 0, done_due = 0, hold_prev = 0;

  always #5 clk = ~clk;

  mac_ifmaps_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols), .cfg_bands(cfg_bands),
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_rdata_row0(memv[0]), .bram_rdata_row1(memv[1]), .bram_rdata_row2(memv[2]),
    .bram_rdata_row3(memv[3]), .bram_rdata_row4(memv[4]),
    .ifmaps_fifo_row0_in(o0), .ifmaps_fifo_row1_in(o1), .ifmaps_fifo_row2_in(o2),
    .ifmaps_fifo_row3_in(o3), .ifmaps_fifo_row4_in(o4),
    .ifmaps_input_valid(valid), .fifo_full(fifo_full), .fifo_read(fifo_read)
  );

  assign rows = {o4, o3, o2, o1, o0};

  function automatic logic [4:0] fmem(input int a);
    return 5'((a * 7 + 3) & 31);
  endfunction

  // Row memory: 1-cycle read latency
  always @(posedge clk) if (bram_en) memv <= fmem(int'(bram_addr));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled 1ns before the rising edge
  initial begin
    forever begin
      bit acc;
      @(negedge clk); #4;
      if (!rst_n) begin
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_en", bram_en, 0); chk("rst_addr", bram_addr, 0);
        chk("rst_valid", valid, 0); chk("rst_rows", rows, 0);
        rd_q.delete(); exp_q.delete();
        busy_due = 0; done_due = 0; hold_prev = 0; start_live = 0;
      end else begin
        chk("done", done, done_due);
        chk("busy", busy, busy_due);
        done_due = 0;
        if (start_live) begin
          start_live = 0;
          if (exp_total == 0) done_due = 1; else busy_due = 1;
        end
        if (bram_en) begin
          issued++;
          if (rd_q.size() == 0) chk("extra_read", 1, 0);
          else chk("rd_addr", bram_addr, rd_q.pop_front());
        end
        if (hold_prev) chk("valid_held", valid, 1);
        acc = valid && (!fifo_full || fifo_read);
        if (valid) begin
          if (exp_q.size() == 0) chk("extra_valid", 1, 0);
          else chk("slice", rows, exp_q[0]);
        end
        if (acc && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          acc_cnt++;
          if (acc_cnt == exp_total) begin done_due = 1; busy_due = 0; end
        end
        checks++;
        if (issued - acc_cnt > 2) begin
          failures++;
          $display("FAIL outstanding: got %0d expected <=2", issued - acc_cnt);
        end
        hold_prev = valid && !acc;
      end
    end
  end

  // mode 0: FIFO never full; 1: full with read every cycle; 2: full without read in cycles 4..9
  task automatic run_job(input int c, input int b, input int mode, input bit extra_start,
                         input int abort_at, output int lat, output int first);
    lat = -1; first = -1;
    exp_total = c * b; issued = 0; acc_cnt = 0;
    for (int bb = 0; bb < b; bb++)
      for (int cc = 0; cc < c; cc++) begin
        rd_q.push_back((bb * c + cc) % 1024);
        exp_q.push_back(fmem((bb * c + cc) % 1024));
      end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        rst_n = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (t == 0) || (extra_start && t == 2);
      if (t == 0) begin cfg_cols = 8'(c); cfg_bands = 6'(b); start_live = 1; end
      if (t == 2 && extra_start) begin cfg_cols = 8'd5; cfg_bands = 6'd5; end
      case (mode)
        1:       begin fifo_full = 1'b1; fifo_read = 1'b1; end
        2:       begin fifo_full = (t >= 4 && t <= 9); fifo_read = 1'b0; end
        default: begin fifo_full = 1'b0; fifo_read = 1'b0; end
      endcase
      #3;
      if (valid && first < 0) first = t;
      if (done) begin lat = t; break; end
    end
    start = 1'b0; fifo_full = 1'b0; fifo_read = 1'b0;
    if (lat < 0) chk("timeout", 1, 0);
    chk("accepts", acc_cnt, c * b);
    chk("drained", exp_q.size() + rd_q.size(), 0);
  endtask

  initial begin
    int lat, first;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("fmem0", fmem(0), 5'b00011);
    run_job(4, 1, 0, 0, -1, lat, first);
    chk("lat_4x1", lat, 7); chk("first_4x1", first, 3);

    run_job(3, 2, 0, 1, -1, lat, first);
    chk("lat_3x2", lat, 9); chk("first_3x2", first, 3);

    run_job(6, 1, 2, 0, -1, lat, first);
    chk("lat_stall", lat, 15);

    run_job(8, 1, 1, 0, -1, lat, first);
    chk("lat_fullrd", lat, 11);

    run_job(0, 3, 0, 0, -1, lat, first);
    chk("lat_zero_cols", lat, 1); chk("first_zero_cols", first, -1);
    run_job(4, 0, 0, 0, -1, lat, first);
    chk("lat_zero_bands", lat, 1); chk("first_zero_bands", first, -1);

    run_job(4, 2, 0, 0, 5, lat, first);
    @(negedge clk);
    run_job(4, 2, 0, 0, -1, lat, first);
    chk("lat_after_rst", lat, 11); chk("first_after_rst", first, 3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
